demux_stream_1_to_n: RTL and testbench
======================================

# demux_stream_1_to_n

Parametrised, registered 1-to-N stream demultiplexer that replaces the combinational 1-to-4 demux wherever data must cross into per-channel consumers with flow control. Each input beat carries a channel select and is steered into a one-entry output register for that channel. A valid/ready handshake runs on the input and on every output. Out-of-range selects are flagged and dropped, never written to a channel.

## Interface
- DATA_W, default 8: payload width in bits, minimum 1.
- N_CH, default 4: number of output channels, range 2..16, need not be a power of two.
- SEL_W, default $clog2(N_CH): select width. Derived; never overridden.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  input beat accepted this cycle when in_valid is also high.
- in_data  in  DATA_W  payload.
- in_sel  in  SEL_W  destination channel index.
- out_valid  out  N_CH  per-channel beat present. Bit i belongs to channel i.
- out_ready  in  N_CH  per-channel consumer ready.
- out_data  out  N_CH*DATA_W  per-channel payload. Channel i occupies bits [i*DATA_W +: DATA_W].
- sel_err  out  1  one-cycle pulse: an out-of-range beat was accepted in the previous cycle.

## Operation
- Each channel holds one slot with two states, EMPTY and FULL.
- EMPTY -> FULL: the channel is loaded.
- FULL -> EMPTY: out_valid[i] and out_ready[i] are both high and the channel is not loaded in the same cycle.
- FULL -> FULL: out_valid[i] and out_ready[i] are both high and the channel is loaded in the same cycle (pass-through). The slot takes the new data.
- Load condition for channel i: in_valid & in_ready & (in_sel == i).
- in_ready for a valid select: ~out_valid[in_sel] | out_ready[in_sel]. This is combinational from in_sel, out_valid and out_ready; it does not depend on in_valid.
- in_ready for in_sel >= N_CH: always 1. The beat is consumed and discarded, no channel changes state, and sel_err is high in the next cycle.
- Only the selected channel is affected by a load. All other slots keep their state and data (no zeroing).
- out_data of an EMPTY channel holds the last loaded value. After reset it is 0.
- A FULL channel holds out_valid and out_data stable until its handshake completes.

## Timing
- Latency: a beat accepted in cycle t appears on out_valid/out_data of its channel in cycle t+1.
- Throughput: one beat per cycle across all channels. One beat per cycle into a single channel is sustained while that channel's out_ready stays high.
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, sel_err = 0.
  - in_ready = 1 for every select, because all slots are EMPTY.
  - Beats held in slots are discarded.
  - The first load can occur on the first rising edge with rst_n high.
- Boundary: channel FULL with out_ready low blocks only beats selecting that channel. Beats selecting other channels still pass.
- Boundary: N_CH not a power of two. Select codes N_CH..2^SEL_W-1 take the out-of-range path.
- Boundary: out_ready is ignored while out_valid is low.

## Configuration
- DEMUX_ERR_CNT_EN defined:
  - Adds output err_cnt [7:0].
  - Increments on each accepted out-of-range beat and saturates at 255.
  - Reset value 0, async, same as the other state.
- DEMUX_ERR_CNT_EN undefined:
  - No err_cnt port and no counter logic.
  - sel_err behaviour is unchanged.

## Structure
- Package demux_pkg holds:
  - typedef slot_state_e {EMPTY, FULL}.
  - Function sel_width(n) returning $clog2(n) with a minimum of 1.
  - localparam ERR_CNT_W = 8.
- Sub-module demux_slot is the one-entry register. Ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data. The top instantiates it N_CH times in a generate loop.
- The top keeps the select decode, the in_ready mux, sel_err and the optional counter.

## Test plan
- Reset mid-stream: fill channels 0 and 2, then pulse rst_n low for 3 ns between edges -> out_valid = 0000 and out_data = 0 immediately; in_ready = 1.
- Steering: DATA_W=8, N_CH=4, send 0xA5 to sel 2 with all out_ready = 0 -> next cycle out_valid = 0100, channel 2 data = 0xA5, other channels' data unchanged.
- Backpressure isolation:
  - Channel 1 is FULL with out_ready[1] = 0, and in_sel = 1 -> in_ready = 0.
  - Switch in_sel to 3 -> in_ready = 1, and the beat lands next cycle.
- Pass-through: channel 0 FULL with 0x11, out_ready[0] = 1, new beat 0x22 to sel 0 -> in_ready = 1, next cycle out_valid[0] = 1 with 0x22, and no bubble.
- Out-of-range:
  - N_CH=5, SEL_W=3, send sel 6 -> in_ready = 1, no out_valid change, sel_err = 1 for exactly one cycle.
  - With DEMUX_ERR_CNT_EN, 260 such beats -> err_cnt = 255.
- Streaming: 100 random beats with random sel and random out_ready -> per-channel output order matches input order, with no loss and no duplication.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
//   slot_state_e : state of a one-entry channel slot (EMPTY / FULL)
//   sel_width()  : select width for n channels, never less than 1
//   ERR_CNT_W    : width of the optional out-of-range beat counter
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int ERR_CNT_W = 8;

    // Number of select bits needed to address n channels (minimum 1).
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register of a single demux channel with valid/ready
// handshake on its output side.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : write load_data into the slot this cycle
//   load_data  : payload to store
//   out_ready  : consumer ready
//   out_valid  : slot holds a beat (state FULL)
//   out_data   : stored payload; keeps the last loaded value while EMPTY
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    slot_state_e       state_r;
    logic [DATA_W-1:0] data_r;

    // Slot state machine and data register. A load while FULL is only
    // granted by the top when out_ready is high, i.e. a pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (load) begin
                        state_r <= FULL;
                        data_r  <= load_data;
                    end else begin
                        state_r <= EMPTY;
                        data_r  <= data_r;
                    end
                end
                FULL: begin
                    if (load) begin
                        state_r <= FULL;
                        data_r  <= load_data;
                    end else if (out_ready) begin
                        state_r <= EMPTY;
                        data_r  <= data_r;
                    end else begin
                        state_r <= FULL;
                        data_r  <= data_r;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    data_r  <= data_r;
                end
            endcase
        end
    end

    assign out_valid = (state_r == FULL);
    assign out_data  = data_r;

endmodule

// File: rtl/demux_stream_1_to_n.sv
// Registered 1-to-N stream demultiplexer. Each accepted input beat is steered
// into the one-entry slot of the channel named by in_sel and appears there one
// cycle later. Selects >= N_CH are accepted, dropped and flagged on sel_err.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready is combinational from
//                         in_sel, out_valid, out_ready; not from in_valid)
//   in_data, in_sel     : payload and destination channel
//   out_valid/out_ready : per-channel output handshake, bit i = channel i
//   out_data            : channel i at [i*DATA_W +: DATA_W]
//   sel_err             : one-cycle pulse after an out-of-range beat
//   err_cnt             : saturating count of out-of-range beats, present
//                         only when DEMUX_ERR_CNT_EN is defined
module demux_stream_1_to_n
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic                   sel_err
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

    logic [N_CH-1:0] sel_onehot_s;
    logic [N_CH-1:0] chan_ready_s;
    logic [N_CH-1:0] load_s;
    logic            sel_in_range_s;
    logic            accept_s;
    logic            oor_accept_s;
    logic            sel_err_r;

    // One extra bit so N_CH == 2**SEL_W compares correctly.
    assign sel_in_range_s = ({1'b0, in_sel} < (SEL_W+1)'(N_CH));
    assign in_ready       = (~sel_in_range_s) | (|(sel_onehot_s & chan_ready_s));
    assign accept_s       = in_valid & in_ready;
    assign oor_accept_s   = accept_s & ~sel_in_range_s;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign sel_onehot_s[i] = (in_sel == SEL_W'(i));
        assign chan_ready_s[i] = ~out_valid[i] | out_ready[i];
        assign load_s[i]       = accept_s & sel_onehot_s[i];

        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_s[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*DATA_W +: DATA_W])
        );
    end

    // Flag an accepted out-of-range beat for exactly the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= oor_accept_s;
        end
    end

    assign sel_err = sel_err_r;

`ifdef DEMUX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Saturating count of dropped out-of-range beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (oor_accept_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_demux_stream_1_to_n.sv
module tb_demux_stream_1_to_n;

    logic        clk;
    logic        rst_n;

    // N_CH = 4 instance
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        sel_err;

    // N_CH = 5 instance (SEL_W = 3)
    logic        in_valid5;
    logic        in_ready5;
    logic [7:0]  in_data5;
    logic [2:0]  in_sel5;
    logic [4:0]  out_valid5;
    logic [4:0]  out_ready5;
    logic [39:0] out_data5;
    logic        sel_err5;

`ifdef DEMUX_ERR_CNT_EN
    logic [7:0]  err_cnt;
    logic [7:0]  err_cnt5;
`endif

    int tests;
    int fails;

    demux_stream_1_to_n #(.DATA_W(8), .N_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err)
`ifdef DEMUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    demux_stream_1_to_n #(.DATA_W(8), .N_CH(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_data   (in_data5),
        .in_sel    (in_sel5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_data  (out_data5),
        .sel_err   (sel_err5)
`ifdef DEMUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs[12];

    // streaming scoreboard
    logic [7:0] exp_mem[4][128];
    int         wr_ptr[4];
    int         rd_ptr[4];

    task automatic pop_check();
        for (int c = 0; c < 4; c++) begin
            if (out_valid[c] && out_ready[c]) begin
                if (rd_ptr[c] < wr_ptr[c]) begin
                    check($sformatf("stream_ch%0d_beat%0d", c, rd_ptr[c]),
                          64'(out_data[c*8 +: 8]), 64'(exp_mem[c][rd_ptr[c]]));
                    rd_ptr[c]++;
                end else begin
                    check($sformatf("stream_ch%0d_extra", c), 64'd1, 64'd0);
                end
            end
        end
    endtask

    initial begin
        int accepted;
        int cyc;
        tests = 0;
        fails = 0;

        // ch3..ch0 packed as {ch3, ch2, ch1, ch0}
        vecs[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000};
        vecs[1]  = '{1'b1, 2'd1, 8'h3C, 4'b0000, 1'b1, 4'b0110, 32'h00A5_3C00};
        vecs[2]  = '{1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, 4'b0110, 32'h00A5_3C00};
        vecs[3]  = '{1'b1, 2'd3, 8'hC3, 4'b0000, 1'b1, 4'b1110, 32'hC3A5_3C00};
        vecs[4]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b1111, 32'hC3A5_3C11};
        vecs[5]  = '{1'b1, 2'd0, 8'h22, 4'b0001, 1'b1, 4'b1111, 32'hC3A5_3C22};
        vecs[6]  = '{1'b0, 2'd0, 8'h33, 4'b0101, 1'b1, 4'b1010, 32'hC3A5_3C22};
        vecs[7]  = '{1'b0, 2'd2, 8'h00, 4'b0000, 1'b1, 4'b1010, 32'hC3A5_3C22};
        vecs[8]  = '{1'b0, 2'd1, 8'h00, 4'b0101, 1'b0, 4'b1010, 32'hC3A5_3C22};
        vecs[9]  = '{1'b1, 2'd1, 8'h44, 4'b0010, 1'b1, 4'b1010, 32'hC3A5_4422};
        vecs[10] = '{1'b1, 2'd3, 8'h55, 4'b1010, 1'b1, 4'b1000, 32'h55A5_4422};
        vecs[11] = '{1'b0, 2'd3, 8'h00, 4'b1000, 1'b1, 4'b0000, 32'h55A5_4422};

        rst_n      = 1'b0;
        in_valid   = 1'b0; in_data  = 8'h00; in_sel  = 2'd0; out_ready  = 4'b0000;
        in_valid5  = 1'b0; in_data5 = 8'h00; in_sel5 = 3'd0; out_ready5 = 5'b00000;
        #3;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_sel_err", 64'(sel_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven steering / backpressure / pass-through
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            in_valid  = vecs[k].v;
            in_sel    = vecs[k].sel;
            in_data   = vecs[k].d;
            out_ready = vecs[k].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].exp_ov));
            check($sformatf("vec%0d_out_data", k), 64'(out_data), 64'(vecs[k].exp_od));
            check($sformatf("vec%0d_sel_err", k), 64'(sel_err), 64'd0);
        end

        // reset mid-stream
        @(negedge clk);
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A; out_ready = 4'b0000;
        @(negedge clk);
        in_sel = 2'd2; in_data = 8'h6B;
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_pre_out_valid", 64'(out_valid), 64'(4'b0101));
        #1 rst_n = 1'b0;
        #1;
        in_sel = 2'd2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        #1 rst_n = 1'b1;

        // out-of-range on N_CH = 5
        @(negedge clk);
        in_valid5 = 1'b1; in_sel5 = 3'd6; in_data5 = 8'hEE;
        #1;
        check("oor6_in_ready", 64'(in_ready5), 64'd1);
        @(posedge clk); #1;
        check("oor6_out_valid", 64'(out_valid5), 64'd0);
        check("oor6_sel_err_hi", 64'(sel_err5), 64'd1);
        @(negedge clk);
        in_valid5 = 1'b1; in_sel5 = 3'd4; in_data5 = 8'h9D;
        #1;
        check("ch4_in_ready", 64'(in_ready5), 64'd1);
        @(posedge clk); #1;
        check("oor6_sel_err_lo", 64'(sel_err5), 64'd0);
        check("ch4_out_valid", 64'(out_valid5), 64'(5'b10000));
        check("ch4_out_data", 64'(out_data5), 64'h9D_0000_0000);
        @(negedge clk);
        in_sel5 = 3'd4; in_data5 = 8'h12;
        #1;
        check("ch4_full_in_ready", 64'(in_ready5), 64'd0);
        in_sel5 = 3'd7;
        #1;
        check("oor7_in_ready", 64'(in_ready5), 64'd1);
        @(posedge clk); #1;
        check("oor7_sel_err", 64'(sel_err5), 64'd1);
        check("oor7_out_data", 64'(out_data5), 64'h9D_0000_0000);
        check("oor7_out_valid", 64'(out_valid5), 64'(5'b10000));
        in_sel5 = 3'd5;
        for (int k = 0; k < 258; k++) begin
            @(posedge clk);
        end
        #1;
        check("oor_stream_sel_err", 64'(sel_err5), 64'd1);
`ifdef DEMUX_ERR_CNT_EN
        check("err_cnt_saturate", 64'(err_cnt5), 64'd255);
`endif
        @(negedge clk);
        in_valid5 = 1'b0;

        // random streaming into N_CH = 4 with scoreboard
        for (int c = 0; c < 4; c++) begin
            wr_ptr[c] = 0;
            rd_ptr[c] = 0;
        end
        accepted = 0;
        cyc = 0;
        while (accepted < 100 && cyc < 3000) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            #1;
            pop_check();
            if (in_valid && in_ready) begin
                exp_mem[in_sel][wr_ptr[in_sel]] = in_data;
                wr_ptr[in_sel]++;
                accepted++;
            end
            cyc++;
        end
        check("stream_accepted", 64'(accepted), 64'd100);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            pop_check();
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stream_ch%0d_drained", c), 64'(rd_ptr[c]), 64'(wr_ptr[c]));
        end
        check("stream_final_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
